slave_write: RTL and testbench
==============================

SLAVE_WRITE -- requirements
Module: slave_write

Interface
REQ-001 SHALL have the following ports, listed as name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, reset, synchronous, active-high.
- AWID, in, AXI_IDS_BITS (8), write address ID.
- AWADDR, in, 32, byte address.
- AWLEN, in, 4, beats minus 1.
- AWSIZE, in, 3, beat size.
- AWBURST, in, 2, burst type.
- AWVALID, in, 1; AWREADY, out, 1.
- WDATA, in, 32; WSTRB, in, 4, active-high byte strobes; WLAST, in, 1; WVALID, in, 1; WREADY, out, 1.
- BID, out, 8; BRESP, out, 2; BVALID, out, 1; BREADY, in, 1.
- mem_web, out, 4, byte write enables, active-low; 4'b1111 means no write.
- mem_addr, out, 14, word address.
- mem_di, out, 32, write data.

REQ-002 SHALL take parameter ADDR_LSB, default 2, which is the low AWADDR bit mapped to mem_addr[0].

Function
REQ-003 SHALL implement three states: IDLE, DATA, RESP.
REQ-004 IDLE behaviour:
- AWREADY=1, WREADY=0, BVALID=0.
- On AWVALID&&AWREADY, latch AWID, AWADDR[15:2], AWLEN and an error flag, then go to DATA.
REQ-005 The error flag SHALL be set when AWBURST!=2'b01 (INCR) or AWSIZE!=3'b010.
REQ-006 DATA behaviour:
- AWREADY=0, WREADY=1.
- Each WVALID&&WREADY is one beat.
- The beat counter starts at 0 and increments per beat.
REQ-007 On each beat with no error, the slave SHALL drive combinationally, in the same cycle:
- mem_web=~WSTRB
- mem_addr=base+count
- mem_di=WDATA
In all other cycles mem_web=4'b1111.
REQ-008 mem_addr SHALL wrap modulo 2^14; no wrap error is flagged.
REQ-009 WLAST mismatch SHALL set the error flag:
- WLAST=1 on a beat with count!=AWLEN, or WLAST=0 on a beat with count==AWLEN.
- Memory writes from that beat onward are suppressed.
REQ-010 DATA SHALL exit to RESP on a beat where WLAST=1 or count==AWLEN, whichever comes first.
REQ-011 RESP behaviour:
- BVALID=1, BID=latched AWID.
- BRESP=2'b10 (SLVERR) if the error flag is set, else 2'b00 (OKAY).
- BID, BRESP and BVALID are held stable until BREADY.
REQ-012 On BVALID&&BREADY, RESP SHALL go to IDLE. AWREADY is reasserted the next cycle; back-to-back throughput is 1 AW per (beats+2) cycles.
REQ-013 A WVALID arriving before AW SHALL NOT be accepted (WREADY=0 in IDLE); the master holds it per AXI.
REQ-014 At most one outstanding write SHALL exist; no AW is accepted in DATA or RESP.
REQ-015 While BVALID is low, BID and BRESP SHALL be 0.
REQ-016 An undefined state SHALL go to IDLE on the next clock, with all outputs at their reset values.

Reset
REQ-017 While rst=1 at a clk edge, the slave SHALL enter IDLE and clear all latched fields, the counter and the error flag.
REQ-018 Output values after reset: AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=0, mem_web=4'b1111, mem_addr=0, mem_di=0.
REQ-019 Reset mid-burst SHALL abandon the transaction: no B response and no further memory writes.

Structure
REQ-020 The shared package (AXI_define) SHALL hold AXI_IDS_BITS, ADDR/DATA/STRB/LEN/SIZE widths, burst codes (INCR=2'b01) and response codes (OKAY, SLVERR, DECERR).
REQ-021 The state encoding SHALL be a typedef enum local to the module.
REQ-022 There SHALL be no sub-module; the counter, latches and FSM live in one always_ff and one always_comb output block.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single write: AWADDR=0x0000_0010, AWLEN=0, WDATA=0xDEADBEEF, WSTRB=4'hF -> mem_addr=4 with mem_web=0000 for one cycle; BRESP=OKAY; BID=AWID.
- Burst: AWADDR=0x100, AWLEN=3, 4 beats, WLAST on beat 4 -> mem_addr 64, 65, 66, 67 in order; one B response with OKAY.
- Partial strobe: WSTRB=4'b0101 -> mem_web=4'b1010 on the beat.
- Bad burst: AWBURST=2'b00 -> no mem_web assertion; BRESP=2'b10.
- Early WLAST: AWLEN=3, WLAST on beat 2 -> 1 write only, then RESP with SLVERR; AWREADY returns after BREADY.
- Backpressure and reset: BREADY low for 5 cycles -> BVALID, BID, BRESP stable throughout. Separately, rst pulsed during beat 2 of a 4-beat burst -> IDLE next cycle, BVALID=0, no further writes.

Source files
------------

// File: rtl/slave_write_pkg.sv
// AXI_define: widths, burst and response codes shared by the AXI slave write-channel logic.
package AXI_define;

   localparam int AXI_IDS_BITS  = 8;
   localparam int AXI_ADDR_BITS = 32;
   localparam int AXI_DATA_BITS = 32;
   localparam int AXI_STRB_BITS = 4;
   localparam int AXI_LEN_BITS  = 4;
   localparam int AXI_SIZE_BITS = 3;
   localparam int MEM_ADDR_BITS = 14;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // Only full 32-bit beats are supported.
   localparam logic [2:0] SIZE_WORD = 3'b010;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/slave_write.sv
// AXI write-channel slave: accepts one INCR burst at a time and drives a word-wide
// SRAM port with active-low byte enables, then returns a single B response.
module slave_write
   import AXI_define::*;
#(
   parameter int ADDR_LSB = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [AXI_IDS_BITS-1:0]  AWID,
   input  logic [AXI_ADDR_BITS-1:0] AWADDR,
   input  logic [AXI_LEN_BITS-1:0]  AWLEN,
   input  logic [AXI_SIZE_BITS-1:0] AWSIZE,
   input  logic [1:0]               AWBURST,
   input  logic                     AWVALID,
   output logic                     AWREADY,
   input  logic [AXI_DATA_BITS-1:0] WDATA,
   input  logic [AXI_STRB_BITS-1:0] WSTRB,
   input  logic                     WLAST,
   input  logic                     WVALID,
   output logic                     WREADY,
   output logic [AXI_IDS_BITS-1:0]  BID,
   output logic [1:0]               BRESP,
   output logic                     BVALID,
   input  logic                     BREADY,
   output logic [AXI_STRB_BITS-1:0] mem_web,
   output logic [MEM_ADDR_BITS-1:0] mem_addr,
   output logic [AXI_DATA_BITS-1:0] mem_di
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [AXI_IDS_BITS-1:0]  id_q, id_d;
   logic [MEM_ADDR_BITS-1:0] base_q, base_d;
   logic [AXI_LEN_BITS-1:0]  len_q, len_d;
   logic [AXI_LEN_BITS-1:0]  cnt_q, cnt_d;
   logic                     err_q, err_d;

   logic last_beat;
   logic wlast_mismatch;
   logic unused_awaddr;

   // Only a window of AWADDR reaches the memory; the rest is intentionally ignored.
   assign unused_awaddr = ^AWADDR;

   assign last_beat      = (cnt_q == len_q);
   assign wlast_mismatch = (WLAST != last_beat);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         id_q    <= '0;
         base_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         base_q  <= base_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      base_d   = base_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      AWREADY  = 1'b0;
      WREADY   = 1'b0;
      BVALID   = 1'b0;
      BID      = '0;
      BRESP    = RESP_OKAY;
      mem_web  = '1;
      mem_addr = '0;
      mem_di   = '0;

      case (state_q)
         S_IDLE: begin
            AWREADY = 1'b1;
            if (AWVALID) begin
               id_d    = AWID;
               base_d  = AWADDR[ADDR_LSB +: MEM_ADDR_BITS];
               len_d   = AWLEN;
               cnt_d   = '0;
               err_d   = (AWBURST != BURST_INCR) || (AWSIZE != SIZE_WORD);
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            WREADY = 1'b1;
            if (WVALID) begin
               // A beat landing in a reset cycle belongs to an abandoned burst.
               if (!err_q && !wlast_mismatch && !rst) begin
                  mem_web  = ~WSTRB;
                  mem_addr = base_q + MEM_ADDR_BITS'(cnt_q);
                  mem_di   = WDATA;
               end
               cnt_d = cnt_q + 1'b1;
               err_d = err_q | wlast_mismatch;
               if (WLAST || last_beat) begin
                  state_d = S_RESP;
               end
            end
         end

         S_RESP: begin
            BVALID = 1'b1;
            BID    = id_q;
            BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
            if (BREADY) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            AWREADY = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_slave_write.sv
// Directed bench for slave_write: stimulus pushes expected memory writes and B
// responses into queues; a negedge monitor pops and compares them.
module tb_slave_write;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  AWID;
   logic [31:0] AWADDR;
   logic [3:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST;
   logic        WVALID;
   logic        WREADY;
   logic [7:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [3:0]  mem_web;
   logic [13:0] mem_addr;
   logic [31:0] mem_di;

   typedef struct {
      logic [13:0] addr;
      logic [3:0]  web;
      logic [31:0] di;
   } wr_t;

   typedef struct {
      logic [7:0] id;
      logic [1:0] resp;
   } b_t;

   wr_t wq[$];
   b_t  bq[$];
   int  errors = 0;
   int  checks = 0;

   slave_write #(.ADDR_LSB(2)) dut (
      .clk(clk), .rst(rst),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .mem_web(mem_web), .mem_addr(mem_addr), .mem_di(mem_di)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every memory write and every B handshake must match the next expectation.
   always @(negedge clk) begin
      if (mem_web !== 4'hF) begin
         if (wq.size() == 0) begin
            chk("unexpected_write", {18'd0, mem_addr}, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = wq.pop_front();
            chk("mem_addr", {18'd0, mem_addr}, {18'd0, e.addr});
            chk("mem_web", {28'd0, mem_web}, {28'd0, e.web});
            chk("mem_di", mem_di, e.di);
            $display("write addr=%0d web=%b di=%h", mem_addr, mem_web, mem_di);
         end
      end
      if (!rst && BVALID && BREADY) begin
         if (bq.size() == 0) begin
            chk("unexpected_b", {24'd0, BID}, 32'hFFFF_FFFF);
         end else begin
            b_t e;
            e = bq.pop_front();
            chk("bid", {24'd0, BID}, {24'd0, e.id});
            chk("bresp", {30'd0, BRESP}, {30'd0, e.resp});
            $display("bresp id=%h resp=%b", BID, BRESP);
         end
      end
   end

   task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [1:0] burst);
      bit ok = 0;
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'b010; AWBURST = burst; AWVALID = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (AWREADY) begin ok = 1; break; end
      end
      chk("aw_accept", {31'd0, ok}, 32'd1);
      chk("wready_idle", {31'd0, WREADY}, 32'd0);
      @(posedge clk); #1;
      AWVALID = 1'b0;
   endtask

   task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                       input bit exp_wr, input logic [13:0] exp_addr);
      bit ok = 0;
      if (exp_wr) wq.push_back('{exp_addr, ~strb, data});
      WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (WREADY) begin ok = 1; break; end
      end
      chk("w_accept", {31'd0, ok}, 32'd1);
      chk("awready_data", {31'd0, AWREADY}, 32'd0);
      @(posedge clk); #1;
      WVALID = 1'b0; WLAST = 1'b0;
   endtask

   task automatic do_b(input logic [7:0] id, input logic [1:0] resp, input int hold);
      bit ok = 0;
      bq.push_back('{id, resp});
      BREADY = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (BVALID) begin ok = 1; break; end
      end
      chk("b_valid", {31'd0, ok}, 32'd1);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("hold_bvalid", {31'd0, BVALID}, 32'd1);
         chk("hold_bid", {24'd0, BID}, {24'd0, id});
         chk("hold_bresp", {30'd0, BRESP}, {30'd0, resp});
      end
      @(posedge clk); #1;
      BREADY = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      BREADY = 1'b0;
      @(negedge clk);
      chk("awready_after_b", {31'd0, AWREADY}, 32'd1);
      chk("bvalid_after_b", {31'd0, BVALID}, 32'd0);
      chk("bid_idle", {24'd0, BID}, 32'd0);
      chk("bresp_idle", {30'd0, BRESP}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", {31'd0, AWREADY}, 32'd1);
      chk("rst_wready", {31'd0, WREADY}, 32'd0);
      chk("rst_bvalid", {31'd0, BVALID}, 32'd0);
      chk("rst_bid", {24'd0, BID}, 32'd0);
      chk("rst_bresp", {30'd0, BRESP}, 32'd0);
      chk("rst_web", {28'd0, mem_web}, 32'hF);
      chk("rst_addr", {18'd0, mem_addr}, 32'd0);
      chk("rst_di", mem_di, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Early W before AW must be held off.
      WVALID = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'hF; WLAST = 1'b1;
      @(negedge clk);
      chk("early_w_wready", {31'd0, WREADY}, 32'd0);
      @(posedge clk); #1;
      WVALID = 1'b0; WLAST = 1'b0;

      // Single write: byte 0x10 -> word 4.
      do_aw(8'hA5, 32'h0000_0010, 4'd0, 2'b01);
      do_w(32'hDEAD_BEEF, 4'hF, 1'b1, 1, 14'd4);
      do_b(8'hA5, 2'b00, 0);

      // Burst of 4 at 0x100 -> words 64..67.
      do_aw(8'h3C, 32'h0000_0100, 4'd3, 2'b01);
      for (int b = 0; b < 4; b++)
         do_w(32'hC0DE_0000 + 32'(b), 4'hF, (b == 3), 1, 14'd64 + 14'(b));
      do_b(8'h3C, 2'b00, 0);

      // Partial strobe, with BREADY held low for 5 cycles.
      do_aw(8'h77, 32'h0000_0020, 4'd0, 2'b01);
      do_w(32'hAABB_CCDD, 4'b0101, 1'b1, 1, 14'd8);
      do_b(8'h77, 2'b00, 5);

      // FIXED burst is refused: no write, SLVERR.
      do_aw(8'h11, 32'h0000_0040, 4'd0, 2'b00);
      do_w(32'h5555_5555, 4'hF, 1'b1, 0, 14'd0);
      do_b(8'h11, 2'b10, 0);

      // Early WLAST on beat 2 of 4: only beat 1 writes.
      do_aw(8'h22, 32'h0000_0200, 4'd3, 2'b01);
      do_w(32'h0000_0001, 4'hF, 1'b0, 1, 14'd128);
      do_w(32'h0000_0002, 4'hF, 1'b1, 0, 14'd0);
      do_b(8'h22, 2'b10, 0);

      // Address wrap: top word then word 0.
      do_aw(8'h44, 32'h0000_FFFC, 4'd1, 2'b01);
      do_w(32'h0BAD_F00D, 4'hF, 1'b0, 1, 14'h3FFF);
      do_w(32'h0BAD_F00E, 4'hF, 1'b1, 1, 14'h0000);
      do_b(8'h44, 2'b00, 0);

      // Reset during beat 2 of 4: burst abandoned, no further writes.
      do_aw(8'h99, 32'h0000_0300, 4'd3, 2'b01);
      do_w(32'hF00D_0001, 4'hF, 1'b0, 1, 14'd192);
      WDATA = 32'hF00D_0002; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_awready", {31'd0, AWREADY}, 32'd1);
      chk("rst_mid_wready", {31'd0, WREADY}, 32'd0);
      chk("rst_mid_bvalid", {31'd0, BVALID}, 32'd0);
      chk("rst_mid_web", {28'd0, mem_web}, 32'hF);
      @(posedge clk); #1;
      WVALID = 1'b0;

      // Recovery after abandoned burst.
      do_aw(8'h5A, 32'h0000_0004, 4'd0, 2'b01);
      do_w(32'h0102_0304, 4'b1000, 1'b1, 1, 14'd1);
      do_b(8'h5A, 2'b00, 0);

      repeat (3) @(posedge clk);
      chk("wq_drained", 32'(wq.size()), 32'd0);
      chk("bq_drained", 32'(bq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
